fir_tap_sequencer: RTL and testbench



---
 rtl/fir_seq_pkg.sv | 38 +++
 rtl/fir_mac_unit.sv | 76 +++++++
 rtl/fir_tap_sequencer.sv | 141 ++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types, default widths and the shift-and-saturate helper for the
// FIR tap sequencer.
package fir_seq_pkg;

    localparam int DEF_NUM_TAPS  = 32;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_COEF_W    = 16;
    localparam int DEF_ACC_W     = 40;
    localparam int DEF_OUT_SHIFT = 15;

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        IDLE   = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        DRAIN  = 3'd4,
        OUTPUT = 3'd5
    } state_t;

    // Arithmetic shift, then clamp into the signed DATA_W range.
    function automatic logic [DEF_DATA_W-1:0] sat_shift(
        input logic signed [DEF_ACC_W-1:0] acc,
        input int                          shift
    );
        logic signed [DEF_ACC_W-1:0] sh;
        logic [DEF_ACC_W-DEF_DATA_W:0] top;
        sh  = acc >>> shift;
        top = sh[DEF_ACC_W-1:DEF_DATA_W-1];
        if (top == '0 || top == '1) begin
            sat_shift = sh[DEF_DATA_W-1:0];
        end else if (sh[DEF_ACC_W-1]) begin
            sat_shift = {1'b1, {(DEF_DATA_W-1){1'b0}}};
        end else begin
            sat_shift = {1'b0, {(DEF_DATA_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with clear/enable and a saturating result
// register loaded on the last tap.
module fir_mac_unit
    import fir_seq_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              last,
    input  logic [DATA_W-1:0] smp,
    input  logic [COEF_W-1:0] coef,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] smp_x;
    logic signed [PROD_W-1:0] coef_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0]        sat_val;

    assign smp_x    = {{COEF_W{smp[DATA_W-1]}}, smp};
    assign coef_x   = {{DATA_W{coef[COEF_W-1]}}, coef};
    assign prod     = smp_x * coef_x;
    assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // The result register samples acc_next so the final tap lands in the
    // same edge that raises result_valid.
    generate
        if (DATA_W == DEF_DATA_W && ACC_W == DEF_ACC_W) begin : g_pkg_sat
            assign sat_val = sat_shift(acc_next, OUT_SHIFT);
        end else begin : g_gen_sat
            logic signed [ACC_W-1:0] shifted;
            logic [ACC_W-DATA_W:0]   top;
            always_comb begin
                shifted = acc_next >>> OUT_SHIFT;
                top     = shifted[ACC_W-1:DATA_W-1];
                if (top == '0 || top == '1) begin
                    sat_val = shifted[DATA_W-1:0];
                end else if (shifted[ACC_W-1]) begin
                    sat_val = {1'b1, {(DATA_W-1){1'b0}}};
                end else begin
                    sat_val = {1'b0, {(DATA_W-1){1'b1}}};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= en & last;
            if (clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc_next;
            end
            if (en && last) begin
                result <= sat_val;
            end
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Per-strobe FIR sequencer: synchronises the sample strobe, writes the sample
// ring, walks every tap through the MAC and reports dropped strobes.
module fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int  NUM_TAPS  = DEF_NUM_TAPS,
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  COEF_W    = DEF_COEF_W,
    parameter int  ACC_W     = DEF_ACC_W,
    parameter int  OUT_SHIFT = DEF_OUT_SHIFT,
    localparam int ADDR_W    = $clog2(NUM_TAPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_strobe,
    input  logic [DATA_W-1:0] sample_in,
    output logic              smp_we,
    output logic [ADDR_W-1:0] smp_addr,
    output logic [DATA_W-1:0] smp_wdata,
    input  logic [DATA_W-1:0] smp_rdata,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_rdata,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic [9:0]        overrun_cnt,
    output logic [2:0]        state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic              sync1, sync2, sync3;
    logic              rise;
    logic              take;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] sample_q;
    logic              tap_vld_d;
    logic              tap_last_d;
    logic              in_flight;

    assign rise      = sync2 & ~sync3;
    assign take      = rise & enable;
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign in_flight = (state == WRITE) || (state == READ) ||
                       (state == DRAIN) || (state == OUTPUT);

    always_comb begin
        state_next = state;
        smp_we     = 1'b0;
        smp_addr   = '0;
        smp_wdata  = '0;
        coef_addr  = '0;
        case (state)
            CLEAR: begin
                smp_we   = 1'b1;
                smp_addr = cnt;
                if (cnt == LAST_IDX) state_next = IDLE;
            end
            IDLE: begin
                if (take) state_next = WRITE;
            end
            WRITE: begin
                smp_we     = 1'b1;
                smp_addr   = wr_ptr;
                smp_wdata  = sample_q;
                state_next = READ;
            end
            READ: begin
                // Newest sample sits at wr_ptr, so tap k looks k slots back.
                smp_addr  = wr_ptr - cnt;
                coef_addr = cnt;
                if (cnt == LAST_IDX) state_next = DRAIN;
            end
            DRAIN:   state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            cnt         <= '0;
            wr_ptr      <= '0;
            sample_q    <= '0;
            tap_vld_d   <= 1'b0;
            tap_last_d  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            sync1      <= sample_strobe;
            sync2      <= sync1;
            sync3      <= sync2;
            state      <= state_next;
            tap_vld_d  <= (state == READ);
            tap_last_d <= (state == READ) && (cnt == LAST_IDX);
            if (state == CLEAR || state == READ) begin
                cnt <= cnt + ADDR_ONE;
            end else begin
                cnt <= '0;
            end
            if (state == IDLE && take) begin
                sample_q <= sample_in;
            end
            if (state == OUTPUT) begin
                wr_ptr <= wr_ptr + ADDR_ONE;
            end
            if (in_flight && take && overrun_cnt != 10'h3FF) begin
                overrun_cnt <= overrun_cnt + 10'd1;
            end
        end
    end

    // result_valid is a one-cycle pulse with no backpressure; result holds
    // its value until the next pulse.
    fir_mac_unit #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .ACC_W    (ACC_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (state == WRITE),
        .en          (tap_vld_d),
        .last        (tap_last_d),
        .smp         (smp_rdata),
        .coef        (coef_rdata),
        .result      (result),
        .result_valid(result_valid)
    );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench: two sequencers (OUT_SHIFT 0 with ramp coefficients,
// OUT_SHIFT 15 with full-scale coefficients) share one stimulus stream.
module tb_fir_tap_sequencer;
    import fir_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        sample_strobe = 1'b0;
    logic [15:0] sample_in = '0;

    logic        imp_we, sat_we;
    logic [4:0]  imp_addr, sat_addr, imp_caddr, sat_caddr;
    logic [15:0] imp_wdata, sat_wdata, imp_rdata, sat_rdata, imp_coef, sat_coef;
    logic [15:0] imp_result, sat_result;
    logic        imp_valid, sat_valid, imp_busy, sat_busy;
    logic [9:0]  imp_ovr, sat_ovr;
    logic [2:0]  imp_state, sat_state;

    logic [15:0] ram_imp [32];
    logic [15:0] ram_sat [32];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cycles = 0;
    int exp_ovr = 0;
    int hist [32];
    int wptr = 0;

    logic [15:0] exp_imp_q [$];
    logic [15:0] exp_sat_q [$];
    int          exp_cyc_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (imp_busy) busy_cycles <= busy_cycles + 1;

    fir_tap_sequencer #(.OUT_SHIFT(0)) dut_imp (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_strobe(sample_strobe),
        .sample_in(sample_in), .smp_we(imp_we), .smp_addr(imp_addr),
        .smp_wdata(imp_wdata), .smp_rdata(imp_rdata), .coef_addr(imp_caddr),
        .coef_rdata(imp_coef), .result(imp_result), .result_valid(imp_valid),
        .busy(imp_busy), .overrun_cnt(imp_ovr), .state_dbg(imp_state)
    );

    fir_tap_sequencer #(.OUT_SHIFT(15)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_strobe(sample_strobe),
        .sample_in(sample_in), .smp_we(sat_we), .smp_addr(sat_addr),
        .smp_wdata(sat_wdata), .smp_rdata(sat_rdata), .coef_addr(sat_caddr),
        .coef_rdata(sat_coef), .result(sat_result), .result_valid(sat_valid),
        .busy(sat_busy), .overrun_cnt(sat_ovr), .state_dbg(sat_state)
    );

    // Synchronous-read sample RAMs and coefficient ROMs.
    always @(posedge clk) begin
        if (imp_we) ram_imp[imp_addr] <= imp_wdata;
        if (sat_we) ram_sat[sat_addr] <= sat_wdata;
        imp_rdata <= ram_imp[imp_addr];
        sat_rdata <= ram_sat[sat_addr];
        imp_coef  <= 16'(imp_caddr) + 16'd1;
        sat_coef  <= 16'h7FFF;
    end

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Direct-form FIR reference with a 40-bit wrapping accumulator.
    function automatic logic [15:0] model(input int shift, input bit ramp);
        longint s;
        logic signed [39:0] a;
        logic signed [39:0] sh;
        s = 0;
        for (int k = 0; k < 32; k++) begin
            s += longint'(hist[(wptr - k) & 31]) * longint'(ramp ? k + 1 : 32767);
        end
        a  = s[39:0];
        sh = a >>> shift;
        if (sh > 40'sd32767) return 16'h7FFF;
        if (sh < -40'sd32768) return 16'h8000;
        return sh[15:0];
    endfunction

    function automatic void accept_hand(input int v, input int e_imp, input int e_sat);
        hist[wptr] = v;
        exp_imp_q.push_back(e_imp[15:0]);
        exp_sat_q.push_back(e_sat[15:0]);
        exp_cyc_q.push_back(cyc + 37);
        wptr = (wptr + 1) & 31;
    endfunction

    function automatic void accept(input int v);
        hist[wptr] = v;
        exp_imp_q.push_back(model(0, 1'b1));
        exp_sat_q.push_back(model(15, 1'b0));
        exp_cyc_q.push_back(cyc + 37);
        wptr = (wptr + 1) & 31;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) hist[i] = 0;
        wptr    = 0;
        exp_ovr = 0;
    endfunction

    // Monitors: every valid pulse must match the head of its queue.
    always @(negedge clk) begin
        if (imp_valid) begin
            if (exp_imp_q.size() == 0) begin
                chk("imp_unexpected_valid", 1, 0);
            end else begin
                chk("imp_result", $signed(imp_result), $signed(exp_imp_q.pop_front()));
                chk("imp_latency", cyc, exp_cyc_q.pop_front());
            end
        end
        if (sat_valid) begin
            if (exp_sat_q.size() == 0) begin
                chk("sat_unexpected_valid", 1, 0);
            end else begin
                chk("sat_result", $signed(sat_result), $signed(exp_sat_q.pop_front()));
            end
        end
    end

    task automatic pulse(input int v, input int hi, input int lo);
        sample_in     = v[15:0];
        sample_strobe = 1'b1;
        repeat (hi) @(negedge clk);
        sample_strobe = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic burst(input int v, input int gap, input int n_drop);
        int t;
        accept(v);
        pulse(v, 2, gap - 2);
        t = gap;
        for (int i = 0; i < n_drop; i++) begin
            pulse(v + i + 1, 2, 2);
            t += 4;
        end
        exp_ovr = (exp_ovr + n_drop > 1023) ? 1023 : exp_ovr + n_drop;
        if (t < 44) repeat (44 - t) @(negedge clk);
    endtask

    // Called right after rst_n rises on a falling edge.
    task automatic check_clear();
        #1;
        chk("rst_busy_imp", imp_busy, 1);
        chk("rst_busy_sat", sat_busy, 1);
        chk("rst_ovr", imp_ovr, 0);
        chk("rst_result", imp_result, 0);
        chk("rst_valid", imp_valid, 0);
        for (int i = 0; i < 32; i++) begin
            chk("clr_we", imp_we, 1);
            chk("clr_addr", imp_addr, i);
            chk("clr_wdata", imp_wdata, 0);
            @(negedge clk);
        end
        chk("clr_done_busy", imp_busy, 0);
        chk("clr_done_state", imp_state, IDLE);
        chk("clr_done_ovr", sat_ovr, 0);
    endtask

    initial begin
        int b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_clear();

        // Impulse response: ramp coefficients come back in order.
        for (int j = 0; j < 41; j++) begin
            accept_hand((j == 0) ? 1 : 0, (j < 32) ? j + 1 : 0, 0);
            pulse((j == 0) ? 1 : 0, 2, 48);
        end

        // Full-scale windows clamp to the rails.
        for (int j = 0; j < 32; j++) begin
            accept(32767);
            pulse(32767, 2, 43);
        end
        chk("sat_pos_hold", $signed(sat_result), 32767);
        for (int j = 0; j < 32; j++) begin
            accept(-32768);
            pulse(-32768, 2, 43);
        end
        chk("sat_neg_hold", $signed(sat_result), -32768);

        // Overrun: one dropped strobe, then enough to saturate the counter.
        burst(100, 10, 1);
        chk("ovr_single", imp_ovr, exp_ovr);
        for (int i = 0; i < 138; i++) begin
            burst((i * 37) % 2000 - 1000, 6, 8);
        end
        chk("ovr_sat_imp", imp_ovr, 1023);
        chk("ovr_sat_sat", sat_ovr, exp_ovr);

        // Disabled strobes are neither processed nor counted.
        enable = 1'b0;
        b0 = busy_cycles;
        for (int i = 0; i < 3; i++) pulse(16'h1234, 2, 43);
        chk("en0_busy", busy_cycles - b0, 0);
        chk("en0_ovr", imp_ovr, exp_ovr);

        // A long strobe level yields exactly one computation.
        enable = 1'b1;
        accept(-555);
        pulse(-555, 200, 50);
        chk("held_ovr", imp_ovr, exp_ovr);

        // Abort mid-READ: no result, CLEAR repeats, next write lands at 0.
        sample_in     = 16'd77;
        sample_strobe = 1'b1;
        repeat (2) @(negedge clk);
        sample_strobe = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_in_read", imp_state, READ);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_clear();
        repeat (5) @(negedge clk);
        accept(500);
        sample_in     = 16'd500;
        sample_strobe = 1'b1;
        repeat (2) @(negedge clk);
        sample_strobe = 1'b0;
        @(negedge clk);
        chk("post_rst_we", imp_we, 1);
        chk("post_rst_addr", imp_addr, 0);
        chk("post_rst_wdata", imp_wdata, 500);
        repeat (60) @(negedge clk);

        chk("drain_imp", exp_imp_q.size(), 0);
        chk("drain_sat", exp_sat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        chk("timeout", 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
